// File: rtl/ps2_led_cmd_ctrl_if.sv
// Bundles the PS/2 LED controller's receive, transmit and status signals.
// The master side is the controller and the slave side is its surroundings.
interface ps2_led_cmd_ctrl_if;
  logic       clk_300k;
  logic       code_new_updated;
  logic [7:0] check_code;
  logic       tx_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [2:0] led_state;
  logic       busy;
  logic       err;

  modport master (
    input  clk_300k, code_new_updated, check_code, tx_ready,
    output tx_start, tx_data, led_state, busy, err
  );
  modport slave (
    output clk_300k, code_new_updated, check_code, tx_ready,
    input  tx_start, tx_data, led_state, busy, err
  );
endinterface

// File: rtl/ps2_led_cmd_ctrl.sv
// Lock-key LED tracker and PS/2 "Set LEDs" (0xED, value) sequencer with timeout and retry.
// Define LEDS_BAT_RESYNC_EN to re-send the LED state after a keyboard self-test byte (0xAA).
module ps2_led_cmd_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 6000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter logic [7:0]  CODE_CAPS   = 8'h58,
  parameter logic [7:0]  CODE_NUM    = 8'h77,
  parameter logic [7:0]  CODE_SCROLL = 8'h7E
) (
  input logic                 clk_2,
  input logic                 rst_n,
  ps2_led_cmd_ctrl_if.master  bus
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] TMAX = ACK_TIMEOUT[TW-1:0];
  localparam logic [RW:0]   RMAX = MAX_RETRY[RW:0];

  typedef enum logic [2:0] {IDLE, SEND_CMD, WAIT_ACK1, SEND_VAL, WAIT_ACK2} state_e;

  state_e        state_q;
  logic          pending_q, brk_q, ext_q, err_q;
  logic [2:0]    held_q, led_q;
  logic [RW-1:0] retry_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    tx_data_q;

  logic       rx, in_wait, is_ack, is_nak, is_f0, is_e0, bat, key, plain, tog, resync, set_pend, timeout;
  logic [2:0] hit;
  logic [RW:0] retry_inc;

  assign rx      = bus.code_new_updated;
  assign in_wait = (state_q == WAIT_ACK1) || (state_q == WAIT_ACK2);
  assign is_ack  = rx && (bus.check_code == 8'hFA);
  assign is_nak  = rx && (bus.check_code == 8'hFE);
  assign is_f0   = bus.check_code == 8'hF0;
  assign is_e0   = bus.check_code == 8'hE0;
  assign hit     = {bus.check_code == CODE_CAPS, bus.check_code == CODE_NUM,
                    bus.check_code == CODE_SCROLL};
`ifdef LEDS_BAT_RESYNC_EN
  assign bat     = rx && (bus.check_code == 8'hAA);
  assign resync  = bat && ((state_q == IDLE) || in_wait);
`else
  assign bat     = 1'b0;
  assign resync  = 1'b0;
`endif
  // ACK/NAK bytes are protocol replies, never keys, and leave break/extend prefixes intact.
  assign key       = rx && !is_ack && !is_nak && !bat;
  assign plain     = key && !is_f0 && !is_e0;
  assign tog       = plain && !brk_q && !ext_q && |(hit & ~held_q);
  assign set_pend  = tog || resync;
  assign timeout   = timer_q >= TMAX;
  assign retry_inc = {1'b0, retry_q} + 1'b1;

  always_ff @(posedge clk_2) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      err_q     <= 1'b0;
      held_q    <= '0;
      led_q     <= '0;
      retry_q   <= '0;
      timer_q   <= '0;
      tx_data_q <= '0;
    end else begin
      if (key) begin
        if (is_f0) brk_q <= 1'b1;
        else if (is_e0) ext_q <= 1'b1;
        else begin
          brk_q <= 1'b0;
          ext_q <= 1'b0;
          for (int i = 0; i < 3; i++) begin
            if (hit[i] && !ext_q) begin
              if (brk_q) held_q[i] <= 1'b0;
              else if (!held_q[i]) begin
                led_q[i]  <= ~led_q[i];
                held_q[i] <= 1'b1;
              end
            end
          end
        end
      end

      if (set_pend) pending_q <= 1'b1;

      case (state_q)
        IDLE: if (pending_q) begin
          pending_q <= set_pend;
          tx_data_q <= 8'hED;
          state_q   <= SEND_CMD;
        end
        SEND_CMD: if (bus.tx_ready) begin
          timer_q <= '0;
          state_q <= WAIT_ACK1;
        end
        SEND_VAL: if (bus.tx_ready) begin
          timer_q <= '0;
          state_q <= WAIT_ACK2;
        end
        WAIT_ACK1, WAIT_ACK2: begin
          if (is_ack) begin
            if (state_q == WAIT_ACK1) begin
              tx_data_q <= {5'b0, led_q};
              state_q   <= SEND_VAL;
            end else begin
              retry_q <= '0;
              err_q   <= 1'b0;
              state_q <= IDLE;
            end
          end else if (is_nak || timeout) begin
            if (retry_inc < RMAX) begin
              retry_q   <= retry_inc[RW-1:0];
              tx_data_q <= 8'hED;
              state_q   <= SEND_CMD;
            end else begin
              retry_q <= '0;
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end else if (bus.clk_300k && !timeout) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // tx_start is gated by the live tx_ready so no pulse can be issued to a busy transmitter.
  assign bus.tx_start  = ((state_q == SEND_CMD) || (state_q == SEND_VAL)) && bus.tx_ready;
  assign bus.tx_data   = tx_data_q;
  assign bus.led_state = led_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_ps2_led_cmd_ctrl.sv
// Directed bench for ps2_led_cmd_ctrl: vector table for the main exchange, hand sequences for
// tx_ready gating, timeout/retry exhaustion, reset abort and 0xAA handling.
module tb_ps2_led_cmd_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_en = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  ps2_led_cmd_ctrl_if bus();

  ps2_led_cmd_ctrl #(.ACK_TIMEOUT(4), .MAX_RETRY(3)) dut (
    .clk_2(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    bus.clk_300k = tick_en && (cyc % 10 == 0);
  end

  typedef struct {
    logic       nu;
    logic [7:0] code;
    logic       st;
    logic [7:0] dat;
    logic [2:0] led;
    logic       bsy;
    logic       er;
  } vec_t;

  vec_t tv[30];

  function automatic vec_t mk(logic nu, logic [7:0] code, logic st, logic [7:0] dat,
                              logic [2:0] led, logic bsy, logic er);
    vec_t v;
    v.nu = nu; v.code = code; v.st = st; v.dat = dat; v.led = led; v.bsy = bsy; v.er = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] b);
    bus.code_new_updated = 1'b1;
    bus.check_code = b;
    @(negedge clk);
    bus.code_new_updated = 1'b0;
  endtask

  // Wait (bounded) for a tx_start pulse, check its byte, then step past it.
  task automatic expect_start(input string nm, input logic [7:0] d);
    int n;
    n = 0;
    while (!bus.tx_start && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_start"}, 32'(bus.tx_start), 32'd1);
    chk({nm, "_data"}, 32'(bus.tx_data), 32'(d));
    @(negedge clk);
  endtask

  initial begin
    logic seen;
    int   cnt;

    tv[0]  = mk(1, 8'h58, 0, 8'h00, 3'b100, 0, 0);
    tv[1]  = mk(0, 8'h00, 1, 8'hED, 3'b100, 1, 0);
    tv[2]  = mk(0, 8'h00, 0, 8'hED, 3'b100, 1, 0);
    tv[3]  = mk(1, 8'hFA, 1, 8'h04, 3'b100, 1, 0);
    tv[4]  = mk(0, 8'h00, 0, 8'h04, 3'b100, 1, 0);
    tv[5]  = mk(1, 8'hFA, 0, 8'h04, 3'b100, 0, 0);
    tv[6]  = mk(1, 8'h77, 0, 8'h04, 3'b110, 0, 0);
    tv[7]  = mk(1, 8'h77, 1, 8'hED, 3'b110, 1, 0);
    tv[8]  = mk(1, 8'h77, 0, 8'hED, 3'b110, 1, 0);
    tv[9]  = mk(1, 8'hF0, 0, 8'hED, 3'b110, 1, 0);
    tv[10] = mk(1, 8'h77, 0, 8'hED, 3'b110, 1, 0);
    tv[11] = mk(1, 8'h77, 0, 8'hED, 3'b100, 1, 0);
    tv[12] = mk(1, 8'hE0, 0, 8'hED, 3'b100, 1, 0);
    tv[13] = mk(1, 8'h77, 0, 8'hED, 3'b100, 1, 0);
    tv[14] = mk(1, 8'hFA, 1, 8'h04, 3'b100, 1, 0);
    tv[15] = mk(0, 8'h00, 0, 8'h04, 3'b100, 1, 0);
    tv[16] = mk(1, 8'hFA, 0, 8'h04, 3'b100, 0, 0);
    tv[17] = mk(0, 8'h00, 1, 8'hED, 3'b100, 1, 0);
    tv[18] = mk(0, 8'h00, 0, 8'hED, 3'b100, 1, 0);
    tv[19] = mk(1, 8'hFE, 1, 8'hED, 3'b100, 1, 0);
    tv[20] = mk(0, 8'h00, 0, 8'hED, 3'b100, 1, 0);
    tv[21] = mk(1, 8'hFA, 1, 8'h04, 3'b100, 1, 0);
    tv[22] = mk(0, 8'h00, 0, 8'h04, 3'b100, 1, 0);
    tv[23] = mk(1, 8'h7E, 0, 8'h04, 3'b101, 1, 0);
    tv[24] = mk(1, 8'hFA, 0, 8'h04, 3'b101, 0, 0);
    tv[25] = mk(0, 8'h00, 1, 8'hED, 3'b101, 1, 0);
    tv[26] = mk(0, 8'h00, 0, 8'hED, 3'b101, 1, 0);
    tv[27] = mk(1, 8'hFA, 1, 8'h05, 3'b101, 1, 0);
    tv[28] = mk(0, 8'h00, 0, 8'h05, 3'b101, 1, 0);
    tv[29] = mk(1, 8'hFA, 0, 8'h05, 3'b101, 0, 0);

    bus.code_new_updated = 1'b0;
    bus.check_code = 8'h00;
    bus.tx_ready = 1'b1;
    bus.clk_300k = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("reset", 32'({bus.tx_start, bus.tx_data, bus.led_state, bus.busy, bus.err}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      bus.code_new_updated = tv[i].nu;
      bus.check_code = tv[i].code;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          32'({bus.tx_start, bus.tx_data, bus.led_state, bus.busy, bus.err}),
          32'({tv[i].st, tv[i].dat, tv[i].led, tv[i].bsy, tv[i].er}));
    end
    bus.code_new_updated = 1'b0;

    // tx_ready low holds the command in SEND_CMD without a pulse
    bus.tx_ready = 1'b0;
    pulse(8'hF0); pulse(8'h58); pulse(8'h58);
    chk("caps_off_led", 32'(bus.led_state), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | bus.tx_start;
    end
    chk("nordy_nostart", 32'(seen), 32'd0);
    chk("nordy_busy", 32'(bus.busy), 32'd1);
    bus.tx_ready = 1'b1;
    #1;
    chk("rdy_start", 32'(bus.tx_start), 32'd1);
    @(negedge clk);
    pulse(8'hFA);
    expect_start("rdy_val", 8'h01);
    pulse(8'hFA);
    @(negedge clk);
    chk("rdy_done", 32'({bus.busy, bus.err}), 32'd0);

    // no replies: three 0xED attempts, then err and IDLE
    pulse(8'hF0); pulse(8'h77); pulse(8'h77);
    chk("num_on_led", 32'(bus.led_state), 32'h3);
    tick_en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.tx_start) begin
        cnt++;
        chk("to_data", 32'(bus.tx_data), 32'hED);
      end
      if (bus.err && !bus.busy) break;
    end
    tick_en = 1'b0;
    chk("to_attempts", 32'(cnt), 32'd3);
    chk("to_err_idle", 32'({bus.err, bus.busy}), 32'b10);

    // a fully acked sequence clears err
    pulse(8'hF0); pulse(8'h7E); pulse(8'h7E);
    expect_start("clr_cmd", 8'hED);
    chk("clr_err_held", 32'(bus.err), 32'd1);
    pulse(8'hFA);
    expect_start("clr_val", 8'h02);
    pulse(8'hFA);
    @(negedge clk);
    chk("clr_done", 32'({bus.busy, bus.err}), 32'd0);

    // reset during a sequence aborts it
    pulse(8'hF0); pulse(8'h58); pulse(8'h58);
    cnt = 0;
    while (!bus.tx_start && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("rst_pre_start", 32'(bus.tx_start), 32'd1);
    rst_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      seen = seen | bus.tx_start;
    end
    chk("rst_nostart", 32'(seen), 32'd0);
    chk("rst_state", 32'({bus.led_state, bus.busy, bus.err, bus.tx_data}), 32'd0);

    // 0xAA after a keyboard power cycle
    pulse(8'h7E);
    expect_start("aa_pre_cmd", 8'hED);
    pulse(8'hFA);
    expect_start("aa_pre_val", 8'h01);
    pulse(8'hFA);
    @(negedge clk);
    pulse(8'hAA);
`ifdef LEDS_BAT_RESYNC_EN
    expect_start("aa_cmd", 8'hED);
    pulse(8'hFA);
    expect_start("aa_val", 8'h01);
    pulse(8'hFA);
    @(negedge clk);
    chk("aa_done", 32'({bus.busy, bus.err, bus.led_state}), 32'h1);
`else
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | bus.tx_start | bus.busy;
    end
    chk("aa_ignored", 32'(seen), 32'd0);
    chk("aa_led", 32'(bus.led_state), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_led_cmd_ctrl.md
Name: ps2_led_cmd_ctrl

Overview:
- Tracks Caps/Num/Scroll Lock state from decoded PS/2 scan codes and keeps the keyboard's own LEDs in sync.
- Sequences the PS/2 host-to-device transmitter through the "Set LEDs" exchange: 0xED, ACK, LED byte, ACK. Handles timeout, resend and retry.
- Sits between the scan-code receiver (check_code / code_new_updated) and the PS/2 transmitter. Also drives the board LED outputs.

Parameters:
- ACK_TIMEOUT, 6000: clk_300k ticks to wait for a keyboard reply (about 20 ms).
- MAX_RETRY, 3: full-sequence attempts before giving up.
- CODE_CAPS, 8'h58: make code for Caps Lock.
- CODE_NUM, 8'h77: make code for Num Lock.
- CODE_SCROLL, 8'h7E: make code for Scroll Lock.

Ports:
- clk_2  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- clk_300k  in  1  one-cycle tick enable (synchronous to clk_2), used for the timeout counter.
- code_new_updated  in  1  one-cycle pulse: check_code holds a new received byte.
- check_code  in  8  received byte.
- tx_ready  in  1  transmitter idle, can accept a byte.
- tx_start  out  1  one-cycle pulse: transmit tx_data.
- tx_data  out  8  byte to transmit; held stable between tx_start pulses.
- led_state  out  3  {caps, num, scroll}, drives the board LEDs.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky: retries exhausted. Cleared on the next fully ACKed sequence or on reset.

Behaviour:
- Reset (rst_n=0 at a clk_2 edge): the following all clear to 0:
  - outputs: led_state, tx_start, tx_data, busy, err.
  - internal: state=IDLE, pending, held[2:0], brk, ext, retry_cnt, timer.
- Key decoder acts only on code_new_updated=1 bytes; all other cycles are ignored.
  - 0xF0: set brk. 0xE0: set ext.
  - 0xFA and 0xFE: never decoded as keys.
  - Any other byte clears both brk and ext after it is processed.
  - byte==CODE_x with brk=1: clear held[x], no toggle.
  - byte==CODE_x with ext=1: ignored.
  - byte==CODE_x with brk=0, ext=0, held[x]=0: toggle led_state[x], set held[x], set pending.
  - held[x]=1 blocks typematic repeats; one toggle per physical press.
- led_state updates on the edge after the byte pulse, independent of FSM state.
- FSM states: IDLE, SEND_CMD, WAIT_ACK1, SEND_VAL, WAIT_ACK2.
- IDLE:
  - If pending, go to SEND_CMD and clear pending.
  - A toggle arriving in any later state re-sets pending; a new sequence starts after return to IDLE.
- SEND_CMD:
  - Wait for tx_ready=1, then pulse tx_start with tx_data=8'hED for exactly one cycle.
  - Clear timer and go to WAIT_ACK1.
- WAIT_ACK1 and WAIT_ACK2:
  - timer increments on each clk_300k tick.
  - 0xFA: WAIT_ACK1 goes to SEND_VAL; WAIT_ACK2 goes to IDLE, clears retry_cnt and err.
  - 0xFE or timer>=ACK_TIMEOUT: retry.
  - Any other byte goes to the key decoder; state unchanged.
- SEND_VAL:
  - Snapshot {5'b0, led_state[2:0]} (scroll=bit0, num=bit1, caps=bit2) on entry.
  - Wait for tx_ready, pulse tx_start, go to WAIT_ACK2.
- Retry:
  - retry_cnt+1. If the new count < MAX_RETRY, return to SEND_CMD (restart from 0xED).
  - Otherwise set err, clear retry_cnt, go to IDLE. pending stays as set by any toggle during the attempt.
- Timer: sized for ACK_TIMEOUT; saturates and does not wrap.
- Latency: tx_start for 0xED is asserted 2 cycles after the toggling byte pulse when tx_ready=1 (one cycle to set pending, one for IDLE->SEND_CMD).
- tx_start is never asserted while tx_ready=0; at most one pulse per SEND_ state.
- Reset mid-sequence aborts immediately; no further tx_start.

Optional Feature:
- Macro: LEDS_BAT_RESYNC_EN.
- Defined: a 0xAA byte (keyboard self-test passed) received in IDLE or a WAIT state sets pending. The current led_state is then re-sent after a keyboard power cycle; 0xAA is not treated as a key.
- Undefined: 0xAA is treated as an ordinary non-lock byte; no resync.

Test Plan:
- Reset, tx_ready=1; pulse 0x58 -> led_state=3'b100, tx_start with tx_data=0xED 2 cycles later, busy=1.
- Continue: reply 0xFA -> tx_start with tx_data=0x04; reply 0xFA -> IDLE, busy=0, err=0.
- Typematic and release: 0x77, 0x77, 0x77, then 0xF0, 0x77, then 0x77 -> led_state[1] toggles on the first and last 0x77 only. 0xE0, 0x77 -> no toggle.
- Resend: first reply 0xFE -> 0xED re-sent; then 0xFA, 0xFA -> complete, retry_cnt=0.
- Timeout: no reply, ACK_TIMEOUT=4 and clk_300k every 10 cycles -> 0xED sent 3 times, then err=1 and IDLE. Next successful sequence clears err.
- Toggle mid-sequence: 0x7E during WAIT_ACK2 -> led_state[0]=1, a second sequence sends value byte 0x05. With LEDS_BAT_RESYNC_EN, 0xAA in IDLE -> a sequence re-sends the current state.
